output_neuron: RTL
==================

# output_neuron

Linear output-layer neuron that sits directly downstream of the hidden `Neuron_ReLU` layer. It consumes the N hidden activations, produces the network output `y`, and on backprop computes the output error `dz_out = y - target`. It also exposes its pre-update weights so each hidden neuron can take `dz_out` on `dZ_in` and its weight on `W_in`. It owns and updates its own weights and bias, using a one-product-per-cycle sequential MAC with a start/done handshake.

## Interface
- `N`, 6, number of inputs (hidden neurons)
- `BITS`, 16, data width, two's-complement fixed point
- `FRAC`, 8, fractional bits (Q8.8 at default)
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high
- `start_fp`  in  1  forward-prop request pulse
- `start_bp`  in  1  backprop request pulse
- `load_w`  in  1  load `w_init`/`b_init` into the weight registers
- `x`  in  N×BITS  hidden-layer outputs
- `w_init`  in  N×BITS  initial weights
- `b_init`  in  BITS  initial bias
- `target`  in  BITS  expected output
- `lr`  in  BITS  negative learning rate (-LR)
- `y`  out  BITS  neuron output
- `dz_out`  out  BITS  output error, drives hidden `dZ_in`
- `w_out`  out  N×BITS  pre-update weights, element i drives hidden neuron i `W_in`
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, FWD, BIAS, DZ, UPD.
- IDLE
  - `start_fp` → FWD: snapshot `x` into `x_q`, clear the accumulator, set index i=0.
  - `start_bp` (without `start_fp`) → DZ: snapshot `x`, `target`, `lr`.
  - Both asserted in the same cycle: FP wins, BP is dropped.
  - `load_w` in IDLE: weights ← `w_init`, bias ← `b_init` on that edge.
  - `load_w` or any start outside IDLE is ignored.
- FWD: each cycle, acc += `x_q[i]`·`w[i]`, i++. Leave for BIAS after i = N-1.
- BIAS: y ← sat(acc + bias). Pulse `done`, return to IDLE.
- DZ: `dz_out` ← sat(y − target); `w_out` ← current weights. Then go to UPD with i=0.
- UPD: each cycle, w[i] ← sat(w[i] + sat(lr·sat(dz·`x_q[i]`))), i++. On the cycle after i = N-1, update bias ← sat(bias + sat(lr·dz)), pulse `done`, return to IDLE.
- Arithmetic
  - Product is the full 2·BITS value, arithmetic-shifted right by FRAC (floor), then saturated to BITS.
  - Accumulator is 2·BITS wide, never saturates internally; saturated only at BIAS.
  - Saturation limits: max 0x7FFF, min 0x8000 (BITS=16).
- BP before any FP uses y = 0.
- `busy` = state ≠ IDLE.
- Reset values
  - Outputs: `y`, `dz_out`, `w_out`, `busy`, `done` = 0.
  - Internal: weights, bias, accumulator = 0; state IDLE.
- `rst` asserted mid-operation: immediate return to IDLE with all reset values. A partially updated weight set is discarded (cleared).

## Timing
- Start is sampled on edge k.
- FP
  - FWD runs on edges k+1..k+N, BIAS on k+N+1.
  - `y` is updated and `done` is high after edge k+N+1, so FP latency is N+1 cycles.
- BP
  - DZ runs on edge k+1; `dz_out` and `w_out` are valid from then on and are stable through `done`.
  - UPD runs on edges k+2..k+N+1; bias updates on k+N+2, when `done` pulses. BP latency is N+2 cycles.
- `done` is high for exactly one cycle. A new start is accepted in the cycle `done` is high (state is IDLE after that edge).
- `y` and `dz_out` hold until overwritten by the next FP or BP.
- `x`, `target`, `lr` need to be valid only on the start edge.

## Structure
- Package `nn_pkg`
  - BITS/FRAC defaults.
  - `MAX_Q`/`MIN_Q` constants.
  - State enum.
  - Functions `fx_mul_sat` and `fx_add_sat`.
- One natural sub-module: `fx_mac`, which computes `fx_mul_sat` plus a wide accumulate, is used in FWD and shares its multiplier with UPD. The UPD chain uses a second `fx_mul_sat` instance.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all outputs 0 immediately; `busy` 0.
- FP: load w=0x0100×6, b=0x0080, x=0x0100×6, pulse `start_fp` → `done` 7 cycles later, `y`=0x0680.
- BP following: target=0x0600, lr=0xFF00 → `dz_out`=0x0080, `w_out`=0x0100×6, `done` 8 cycles after start; next FP gives `y`=0x0300 (weights 0x0080, bias 0).
- Saturation: w=0x7FFF, x=0x7FFF, b=0x7FFF → `y`=0x7FFF; with x=0x8000 → `y`=0x8000.
- Handshake: `start_fp` and `start_bp` in the same cycle → only FP runs (7-cycle `done`, `dz_out` unchanged); `start_bp` and `load_w` while busy → ignored.
- Reset during UPD (edge k+4) → IDLE, weights 0; subsequent FP gives `y`=0.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared fixed-point types and saturating arithmetic for the output-layer neuron.
// Values are two's-complement Q(BITS-FRAC).FRAC; products are floored, then clamped.
package nn_pkg;
    localparam int BITS = 16;
    localparam int FRAC = 8;
    localparam int WIDE = 2 * BITS;

    localparam logic signed [BITS-1:0] MAX_Q = 16'sh7FFF;
    localparam logic signed [BITS-1:0] MIN_Q = 16'sh8000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FWD  = 3'd1,
        ST_BIAS = 3'd2,
        ST_DZ   = 3'd3,
        ST_UPD  = 3'd4
    } state_e;

    function automatic logic signed [WIDE+1:0] fx_sext(input logic signed [BITS-1:0] a);
        return {{(WIDE+2-BITS){a[BITS-1]}}, a};
    endfunction

    function automatic logic signed [BITS-1:0] fx_sat(input logic signed [WIDE+1:0] v);
        logic signed [WIDE+1:0] hi;
        logic signed [WIDE+1:0] lo;
        hi = fx_sext(MAX_Q);
        lo = fx_sext(MIN_Q);
        if (v > hi) begin
            return MAX_Q;
        end else if (v < lo) begin
            return MIN_Q;
        end else begin
            return v[BITS-1:0];
        end
    endfunction

    // Arithmetic right shift floors toward minus infinity, as the datapath requires.
    function automatic logic signed [BITS-1:0] fx_mul_sat(input logic signed [BITS-1:0] a,
                                                          input logic signed [BITS-1:0] b);
        logic signed [WIDE-1:0] ae;
        logic signed [WIDE-1:0] be;
        logic signed [WIDE-1:0] p;
        logic signed [WIDE-1:0] ps;
        ae = {{BITS{a[BITS-1]}}, a};
        be = {{BITS{b[BITS-1]}}, b};
        p  = ae * be;
        ps = p >>> FRAC;
        return fx_sat({{2{ps[WIDE-1]}}, ps});
    endfunction

    function automatic logic signed [BITS-1:0] fx_add_sat(input logic signed [BITS-1:0] a,
                                                          input logic signed [BITS-1:0] b);
        return fx_sat(fx_sext(a) + fx_sext(b));
    endfunction
endpackage

// File: rtl/fx_mac.sv
// Single saturating fixed-point multiplier with a full-width accumulate of its product.
// The accumulate path never clamps; the caller saturates when it commits a result.
module fx_mac
    import nn_pkg::*;
(
    input  logic signed [BITS-1:0] a_i,
    input  logic signed [BITS-1:0] b_i,
    input  logic signed [WIDE-1:0] acc_i,
    output logic signed [BITS-1:0] prod_o,
    output logic signed [WIDE-1:0] acc_o
);
    // Multiply, clamp to BITS, then sign-extend into the wide accumulator.
    always_comb begin
        prod_o = fx_mul_sat(a_i, b_i);
        acc_o  = acc_i + {{(WIDE-BITS){prod_o[BITS-1]}}, prod_o};
    end
endmodule

// File: rtl/output_neuron.sv
// Linear output neuron: sequential MAC forward pass, output error, and in-place SGD
// update of its own weights and bias, one product per cycle, with a start/done handshake.
module output_neuron
    import nn_pkg::*;
#(
    parameter int N = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_fp,
    input  logic                   start_bp,
    input  logic                   load_w,
    input  logic [N-1:0][BITS-1:0] x,
    input  logic [N-1:0][BITS-1:0] w_init,
    input  logic [BITS-1:0]        b_init,
    input  logic [BITS-1:0]        target,
    input  logic [BITS-1:0]        lr,
    output logic [BITS-1:0]        y,
    output logic [BITS-1:0]        dz_out,
    output logic [N-1:0][BITS-1:0] w_out,
    output logic                   busy,
    output logic                   done
);
    localparam int IW = $clog2(N + 1);
    localparam logic [IW-1:0] IDX_ZERO = IW'(32'd0);
    localparam logic [IW-1:0] IDX_ONE  = IW'(32'd1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [IW-1:0] IDX_END  = IW'(N);

    state_e                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic signed [WIDE-1:0] acc_q, acc_d;
    logic [N-1:0][BITS-1:0] x_q, x_d, w_q, w_d, w_out_q, w_out_d;
    logic signed [BITS-1:0] bias_q, bias_d, target_q, target_d, lr_q, lr_d;
    logic signed [BITS-1:0] y_q, y_d, dz_q, dz_d;
    logic                   done_q, done_d;

    logic [IW-1:0]          sel_s;
    logic signed [BITS-1:0] mac_a_s, mac_b_s, prod_s;
    logic signed [WIDE-1:0] mac_sum_s;

    // The index reaches N only on the final bias step of UPD; keep array selects in range.
    assign sel_s = (idx_q != IDX_END) ? idx_q : IDX_ZERO;

    fx_mac u_mac (
        .a_i    (mac_a_s),
        .b_i    (mac_b_s),
        .acc_i  (acc_q),
        .prod_o (prod_s),
        .acc_o  (mac_sum_s)
    );

    // Multiplier operand select: x*w in FWD, dz*x per weight in UPD, then lr*dz for the bias.
    always_comb begin
        mac_a_s = {BITS{1'b0}};
        mac_b_s = {BITS{1'b0}};
        case (state_q)
            ST_FWD: begin
                mac_a_s = x_q[sel_s];
                mac_b_s = w_q[sel_s];
            end
            ST_UPD: begin
                if (idx_q != IDX_END) begin
                    mac_a_s = dz_q;
                    mac_b_s = x_q[sel_s];
                end else begin
                    mac_a_s = lr_q;
                    mac_b_s = dz_q;
                end
            end
            default: begin
                mac_a_s = {BITS{1'b0}};
                mac_b_s = {BITS{1'b0}};
            end
        endcase
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        x_d      = x_q;
        w_d      = w_q;
        bias_d   = bias_q;
        target_d = target_q;
        lr_d     = lr_q;
        y_d      = y_q;
        dz_d     = dz_q;
        w_out_d  = w_out_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_w) begin
                    w_d    = w_init;
                    bias_d = b_init;
                end else begin
                    w_d    = w_q;
                end
                if (start_fp) begin
                    x_d     = x;
                    acc_d   = {WIDE{1'b0}};
                    idx_d   = IDX_ZERO;
                    state_d = ST_FWD;
                end else if (start_bp) begin
                    x_d      = x;
                    target_d = target;
                    lr_d     = lr;
                    state_d  = ST_DZ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FWD: begin
                acc_d = mac_sum_s;
                if (idx_q == IDX_LAST) begin
                    state_d = ST_BIAS;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end
            ST_BIAS: begin
                y_d     = fx_sat({{2{acc_q[WIDE-1]}}, acc_q} + fx_sext(bias_q));
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_DZ: begin
                dz_d    = fx_sat(fx_sext(y_q) - fx_sext(target_q));
                w_out_d = w_q;
                idx_d   = IDX_ZERO;
                state_d = ST_UPD;
            end
            ST_UPD: begin
                if (idx_q != IDX_END) begin
                    w_d[sel_s] = fx_add_sat(w_q[sel_s], fx_mul_sat(lr_q, prod_s));
                    idx_d      = idx_q + IDX_ONE;
                end else begin
                    bias_d  = fx_add_sat(bias_q, prod_s);
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partially updated weight set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= IDX_ZERO;
            acc_q    <= {WIDE{1'b0}};
            x_q      <= {(N*BITS){1'b0}};
            w_q      <= {(N*BITS){1'b0}};
            bias_q   <= {BITS{1'b0}};
            target_q <= {BITS{1'b0}};
            lr_q     <= {BITS{1'b0}};
            y_q      <= {BITS{1'b0}};
            dz_q     <= {BITS{1'b0}};
            w_out_q  <= {(N*BITS){1'b0}};
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            w_q      <= w_d;
            bias_q   <= bias_d;
            target_q <= target_d;
            lr_q     <= lr_d;
            y_q      <= y_d;
            dz_q     <= dz_d;
            w_out_q  <= w_out_d;
            done_q   <= done_d;
        end
    end

    assign y      = y_q;
    assign dz_out = dz_q;
    assign w_out  = w_out_q;
    assign done   = done_q;
    assign busy   = (state_q != ST_IDLE);
endmodule
